// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_rst_state_t;

  localparam int LOSS_CNT_W = 8;

  // One counter serves both windows, so size it for the larger one (never below 1 bit).
  function automatic int cnt_width(input int lock_cycles, input int hold_cycles);
    int max_cycles;
    int w;
    max_cycles = (lock_cycles > hold_cycles) ? lock_cycles : hold_cycles;
    w = $clog2(max_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock/reset handshake between the PLL wrapper and the reset sequencer.
interface pll_reset_sequencer_if;
  import pll_reset_pkg::*;

  logic                  locked;
  logic                  soft_reset_req;
  logic                  sys_reset_n;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_count;

  modport master (
    output locked,
    output soft_reset_req,
    input  sys_reset_n,
    input  ready,
    input  lock_loss_count
  );

  modport slave (
    input  locked,
    input  soft_reset_req,
    output sys_reset_n,
    output ready,
    output lock_loss_count
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low clear to 0.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// System reset generator for the PLL output clock domain, driven by PLL lock.
// Define PLL_RESET_LOSS_COUNT_EN to build the saturating lock-loss counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_LOCK | reset asserted, waiting for synchronised lock
// STABILIZE | lock seen, counting LOCK_CYCLES of continuous lock
// HOLD      | lock qualified, stretching reset for HOLD_CYCLES
// RUN       | reset released, sys_reset_n/ready high
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pll_reset_sequencer_if.slave  bus
);

  localparam int CNT_W = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  pll_rst_state_t   state;
  pll_rst_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             locked_sync;
  logic             run_q;

  sync_2ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.locked),
    .q       (locked_sync)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      run_q <= (state_nxt == RUN);
    end
  end

  // Lock loss is checked first in every state so it always beats a soft reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_sync) state_nxt = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (bus.soft_reset_req) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (bus.soft_reset_req) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.sys_reset_n = run_q;
  assign bus.ready       = run_q;

`ifdef PLL_RESET_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt <= '0;
    end else if ((state == RUN) && !locked_sync && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign bus.lock_loss_count = loss_cnt;
`else
  assign bus.lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed-vector bench for pll_reset_sequencer with LOCK_CYCLES=4, HOLD_CYCLES=2.
module tb_pll_reset_sequencer;
  import pll_reset_pkg::*;

  localparam int LOCK_CYCLES = 4;
  localparam int HOLD_CYCLES = 2;
  localparam int REL_EDGE    = LOCK_CYCLES + HOLD_CYCLES + 3;

  logic clock;
  logic reset_n;
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   exp_loss = 0;

  pll_reset_sequencer_if bus_if ();

  pll_reset_sequencer #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic note_loss();
`ifdef PLL_RESET_LOSS_COUNT_EN
    if (exp_loss < 255) exp_loss++;
`endif
  endtask

  task automatic do_reset();
    bus_if.locked         = 1'b0;
    bus_if.soft_reset_req = 1'b0;
    reset_n               = 1'b0;
    tick(2);
    reset_n  = 1'b1;
    exp_loss = 0;
  endtask

  initial begin
    // power-up: outputs held low during reset even with lock present
    reset_n               = 1'b0;
    bus_if.locked         = 1'b1;
    bus_if.soft_reset_req = 1'b0;
    tick(3);
    chk("rst_sys", bus_if.sys_reset_n, 0);
    chk("rst_ready", bus_if.ready, 0);
    chk("rst_count", bus_if.lock_loss_count, 0);
    reset_n = 1'b1;
    tick(REL_EDGE - 1);
    chk("pwr_pre", bus_if.sys_reset_n, 0);
    tick();
    chk("pwr_rel", bus_if.sys_reset_n, 1);
    chk("pwr_ready", bus_if.ready, 1);

    // lock loss in RUN
    bus_if.locked = 1'b0;
    tick(2);
    chk("loss_e2", bus_if.sys_reset_n, 1);
    tick();
    note_loss();
    chk("loss_e3", bus_if.sys_reset_n, 0);
    chk("loss_ready", bus_if.ready, 0);
    chk("loss_count", bus_if.lock_loss_count, exp_loss);
    bus_if.locked = 1'b1;
    tick(REL_EDGE - 1);
    chk("relock_pre", bus_if.sys_reset_n, 0);
    tick();
    chk("relock_rel", bus_if.sys_reset_n, 1);

    // single soft reset pulse: low for HOLD_CYCLES cycles
    bus_if.soft_reset_req = 1'b1;
    tick();
    bus_if.soft_reset_req = 1'b0;
    chk("soft_e1", bus_if.sys_reset_n, 0);
    tick();
    chk("soft_e2", bus_if.sys_reset_n, 0);
    tick();
    chk("soft_e3", bus_if.sys_reset_n, 1);

    // second pulse while in HOLD restarts the window
    bus_if.soft_reset_req = 1'b1;
    tick();
    chk("dsoft_e1", bus_if.sys_reset_n, 0);
    tick();
    bus_if.soft_reset_req = 1'b0;
    chk("dsoft_e2", bus_if.sys_reset_n, 0);
    tick();
    chk("dsoft_e3", bus_if.sys_reset_n, 0);
    tick();
    chk("dsoft_e4", bus_if.sys_reset_n, 1);

    // lock loss and soft reset on the same edge: lock loss wins
    bus_if.locked = 1'b0;
    tick(2);
    bus_if.soft_reset_req = 1'b1;
    tick();
    bus_if.soft_reset_req = 1'b0;
    note_loss();
    chk("prio_sys", bus_if.sys_reset_n, 0);
    chk("prio_state", dut.state, WAIT_LOCK);
    chk("prio_count", bus_if.lock_loss_count, exp_loss);

    // qualification abort: one-cycle drop inside STABILIZE
    do_reset();
    bus_if.locked = 1'b1;
    tick(4);
    bus_if.locked = 1'b0;
    tick();
    bus_if.locked = 1'b1;
    tick();
    tick(3);
    chk("abort_e9", bus_if.sys_reset_n, 0);
    tick(4);
    chk("abort_pre", bus_if.sys_reset_n, 0);
    tick();
    chk("abort_rel", bus_if.sys_reset_n, 1);
    chk("abort_count", bus_if.lock_loss_count, 0);

    // saturation over 260 lock-loss events
    do_reset();
    bus_if.locked = 1'b1;
    tick(REL_EDGE);
    chk("sat_run", bus_if.sys_reset_n, 1);
    for (int i = 0; i < 260; i++) begin
      bus_if.locked = 1'b0;
      tick(3);
      note_loss();
      if (i == 253) chk("sat_254", bus_if.lock_loss_count, exp_loss);
      if (i == 254) chk("sat_255", bus_if.lock_loss_count, exp_loss);
      bus_if.locked = 1'b1;
      tick(REL_EDGE);
    end
    chk("sat_final", bus_if.lock_loss_count, exp_loss);
`ifdef PLL_RESET_LOSS_COUNT_EN
    chk("sat_value", bus_if.lock_loss_count, 255);
`else
    chk("sat_value", bus_if.lock_loss_count, 0);
`endif
    chk("sat_sys", bus_if.sys_reset_n, 1);

    // asynchronous reset clears everything mid-cycle
    reset_n = 1'b0;
    #1;
    chk("async_sys", bus_if.sys_reset_n, 0);
    chk("async_count", bus_if.lock_loss_count, 0);
    chk("async_state", dut.state, WAIT_LOCK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Generates the system reset for the PLL output clock domain from the PLL `locked` indication. Synchronises `locked`, requires it to be continuously high for a qualification window, stretches reset for a hold window, then releases a clean synchronous reset. On loss of lock it re-asserts reset. Sits directly after the PLL instance at top level; every block clocked from the PLL output takes its reset from `sys_reset_n`.

## Interface
- `LOCK_CYCLES`, 1024: consecutive cycles `locked` must be high before hold starts; must be ≥1.
- `HOLD_CYCLES`, 16: cycles reset stays asserted after qualification; must be ≥1.
- `clock`  in  1  PLL output clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset (board/power-on reset).
- `locked`  in  1  PLL lock indication; asynchronous to `clock`.
- `soft_reset_req`  in  1  synchronous single-cycle request to re-run the hold window.
- `sys_reset_n`  out  1  synchronous active-low system reset; high only in RUN.
- `ready`  out  1  high only in RUN; identical to `sys_reset_n`.
- `lock_loss_count`  out  8  saturating count of RUN→WAIT_LOCK transitions.

## Operation
- `locked` passes through a 2-flop synchroniser; internal `locked_sync` is `locked` delayed 2 edges.
- Counter `cnt` has width `$clog2(max(LOCK_CYCLES,HOLD_CYCLES))`, minimum 1.
- States:
  - WAIT_LOCK: `cnt`=0. Goes to STABILIZE when `locked_sync`=1.
  - STABILIZE: `cnt` increments while `locked_sync`=1. At `cnt`==LOCK_CYCLES-1 with `locked_sync`=1, goes to HOLD with `cnt`=0. `locked_sync`=0 goes to WAIT_LOCK with `cnt`=0.
  - HOLD: `cnt` increments. At `cnt`==HOLD_CYCLES-1, goes to RUN. `locked_sync`=0 goes to WAIT_LOCK.
  - RUN: `locked_sync`=0 goes to WAIT_LOCK and increments `lock_loss_count`; `soft_reset_req`=1 goes to HOLD with `cnt`=0.
- Priority: `locked_sync`=0 beats `soft_reset_req` in every state.
- `soft_reset_req` is ignored in WAIT_LOCK and STABILIZE. In HOLD it restarts `cnt` at 0.
- `lock_loss_count` saturates at 255 and clears only on `reset_n`.
- Lock loss in STABILIZE or HOLD does not increment `lock_loss_count`.
- Outputs are registered state decodes with no combinational path from inputs.

## Timing
- Reset (`reset_n`=0, asynchronous): state WAIT_LOCK, `cnt`=0, synchroniser flops 0, `sys_reset_n`=0, `ready`=0, `lock_loss_count`=0.
- Release latency: `locked` stable high from the edge that first samples it (edge 1), `sys_reset_n` rises after edge LOCK_CYCLES+HOLD_CYCLES+3. With defaults this is edge 1043.
- Lock-loss latency: `locked` falls, first sampled at edge 1; `sys_reset_n` falls after edge 3.
- Soft reset: `soft_reset_req` high at edge 1 while in RUN. `sys_reset_n` falls after edge 1 and rises after edge HOLD_CYCLES+1.
- A `locked` glitch shorter than one clock period may be missed; any glitch that is sampled restarts qualification.
- Deassertion of `reset_n` is assumed to be synchronised externally; this block provides no reset synchroniser for `reset_n` itself.

## Configuration
- `PLL_RESET_LOSS_COUNT_EN`
  - Defined: the `lock_loss_count` register and its increment logic are built as described.
  - Undefined: `lock_loss_count` is tied to 8'd0 and no counter flops exist. All other behaviour is unchanged.

## Structure
- Package `pll_reset_pkg` holds:
  - state enum `pll_rst_state_t` {WAIT_LOCK, STABILIZE, HOLD, RUN}, 2 bits;
  - `LOSS_CNT_W`=8.
- Sub-module `sync_2ff`: a 2-flop synchroniser with asynchronous active-low reset to 0. It is reusable elsewhere, so it is a separate module.

## Test plan
Parameters for all scenarios: LOCK_CYCLES=4, HOLD_CYCLES=2.
- Power-up: `reset_n` low, `locked`=1 → all outputs 0. Release `reset_n`, `locked` held high → `sys_reset_n` rises exactly after edge 9.
- Qualification abort: `locked` high for 3 sampled edges inside STABILIZE, then low for 1, then high → `sys_reset_n` rises 9 edges after the final rise. `lock_loss_count`=0.
- Lock loss in RUN: drop `locked` → `sys_reset_n`=0 after edge 3 and `lock_loss_count`=1. Relock → release again 9 edges later.
- Soft reset: in RUN, pulse `soft_reset_req` 1 cycle → `sys_reset_n` low for exactly 2 cycles. A second pulse during HOLD extends the low period by the restart.
- Priority: `soft_reset_req`=1 on the same edge `locked_sync` falls in RUN → state WAIT_LOCK and count increments.
- Saturation: 260 lock-loss cycles → `lock_loss_count`=255. Without `PLL_RESET_LOSS_COUNT_EN` it stays 0.
